arinc_tx24: RTL

- Transmit stage directly upstream of the 24-bit bipolar return-to-zero receiver.
- Accepts a 24-bit word through a start/busy handshake and serialises it LSB first on the differential pair TxA/TxB.
- Each bit is a data phase followed by a zero phase; each word is followed by a null gap.
- Runs at a high or low bit rate, selected per word, so that it matches the receiver's sampling clocks.

---
 rtl/arinc_tx24.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/arinc_tx24.sv
// ---------------------------------------------------------------------------
// arinc_tx24
//
// Bipolar return-to-zero transmitter for 24-bit words. A word is accepted
// through a start/busy handshake and sent LSB first on the differential pair
// TxA/TxB. Every bit is one data phase followed by one zero phase, and every
// word is followed by GAP_PHASES null phases so the receiver can detect the
// end of the frame. The phase length is chosen per word (high or low rate).
//
// Ports:
//   clk          system clock, all logic on the rising edge
//   rst          synchronous active-high reset
//   tx_rate_sel  1 = HI_PHASE cycles per phase, 0 = LO_PHASE (sampled at start)
//   dat24        word to transmit (sampled at start)
//   tx_start     transmit request, honoured only while tx_busy is low
//   tx_busy      high from the cycle after acceptance to the end of the gap
//   tx_done      one-cycle pulse when a frame, including its gap, completes
//   TxA          line A, high during a '1' data phase
//   TxB          line B, high during a '0' data phase
// ---------------------------------------------------------------------------
module arinc_tx24 #(
   parameter int HI_PHASE   = 502,
   parameter int LO_PHASE   = 5020502,
   parameter int GAP_PHASES = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        tx_rate_sel,
   input  logic [23:0] dat24,
   input  logic        tx_start,
   output logic        tx_busy,
   output logic        tx_done,
   output logic        TxA,
   output logic        TxB
);

   // The phase counter only ever holds P-1, so clog2 of the longest phase fits.
   localparam int PMAX = (LO_PHASE > HI_PHASE) ? LO_PHASE : HI_PHASE;
   localparam int CW   = (PMAX > 1) ? $clog2(PMAX) : 1;
   localparam int GW   = (GAP_PHASES > 1) ? $clog2(GAP_PHASES) : 1;

   localparam logic [CW-1:0] HI_LOAD  = CW'(HI_PHASE - 1);
   localparam logic [CW-1:0] LO_LOAD  = CW'(LO_PHASE - 1);
   localparam logic [GW-1:0] GAP_LAST = GW'(GAP_PHASES - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_DATA = 2'd1,
      ST_ZERO = 2'd2,
      ST_GAP  = 2'd3
   } state_t;

   state_t        state_q, state_d;
   logic [23:0]   sr_q,    sr_d;
   logic          rate_q,  rate_d;
   logic [CW-1:0] cnt_q,   cnt_d;
   logic [4:0]    bit_q,   bit_d;
   logic [GW-1:0] gap_q,   gap_d;
   logic          txa_q,   txa_d;
   logic          txb_q,   txb_d;
   logic          busy_q,  busy_d;
   logic          done_q,  done_d;
   logic [CW-1:0] reload;

   // Next-state logic. Line levels and busy are derived from the next state
   // so that every output is a flop and changes exactly on the state edge.
   always_comb begin
      state_d = state_q;
      sr_d    = sr_q;
      rate_d  = rate_q;
      cnt_d   = cnt_q;
      bit_d   = bit_q;
      gap_d   = gap_q;
      done_d  = 1'b0;
      reload  = rate_q ? HI_LOAD : LO_LOAD;

      case (state_q)
         ST_IDLE: begin
            if (tx_start) begin
               sr_d    = dat24;
               rate_d  = tx_rate_sel;
               cnt_d   = tx_rate_sel ? HI_LOAD : LO_LOAD;
               bit_d   = 5'd0;
               gap_d   = '0;
               state_d = ST_DATA;
            end
         end

         ST_DATA: begin
            if (cnt_q == '0) begin
               cnt_d   = reload;
               state_d = ST_ZERO;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end

         // The shift happens at the end of the zero phase so sr[0] is always
         // the bit being shown in the data phase that follows.
         ST_ZERO: begin
            if (cnt_q == '0) begin
               cnt_d = reload;
               sr_d  = sr_q >> 1;
               bit_d = bit_q + 5'd1;
               if (bit_q == 5'd23) begin
                  gap_d   = '0;
                  state_d = ST_GAP;
               end else begin
                  state_d = ST_DATA;
               end
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end

         ST_GAP: begin
            if (cnt_q == '0) begin
               cnt_d = reload;
               if (gap_q == GAP_LAST) begin
                  state_d = ST_IDLE;
                  done_d  = 1'b1;
               end else begin
                  gap_d = gap_q + GW'(1);
               end
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase

      txa_d  = (state_d == ST_DATA) &&  sr_d[0];
      txb_d  = (state_d == ST_DATA) && !sr_d[0];
      busy_d = (state_d != ST_IDLE);
   end

   // State and output registers; reset aborts any frame in progress.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         sr_q    <= '0;
         rate_q  <= 1'b0;
         cnt_q   <= '0;
         bit_q   <= '0;
         gap_q   <= '0;
         txa_q   <= 1'b0;
         txb_q   <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         sr_q    <= sr_d;
         rate_q  <= rate_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         gap_q   <= gap_d;
         txa_q   <= txa_d;
         txb_q   <= txb_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign TxA     = txa_q;
   assign TxB     = txb_q;
   assign tx_busy = busy_q;
   assign tx_done = done_q;

endmodule
